compressor_stream_arbiter: RTL

COMPRESSOR_STREAM_ARBITER -- requirements
Module: compressor_stream_arbiter

---
 rtl/compressor_stream_arbiter_pkg.sv | 19 +
 rtl/compressor_stream_arbiter_skid.sv | 66 ++++++
 rtl/compressor_stream_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/compressor_stream_arbiter_pkg.sv
// Shared defaults and arbiter state encoding for the compressor input arbiter.
// Imported by the arbiter top and its output skid buffer.
package compressor_stream_arbiter_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 256;
  localparam int KEEP_WIDTH_DEF = DATA_WIDTH_DEF / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // Port-id width, kept at least one bit so a single-port build still has an m_tid.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/compressor_stream_arbiter_skid.sv
// Two-entry output buffer: a pushed beat is valid on the output the next cycle.
// in_rdy depends only on registered occupancy; out_rdy low holds the head entry stable.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push, pop;

  assign in_rdy  = (count_q != 2'd2);
  assign out_vld = (count_q != 2'd0);
  assign out_dat = head_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_dat;
        else                 tail_d = in_dat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Push with pop only happens below full, so occupancy is unchanged.
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_dat;
        end else begin
          head_d = tail_q;
          tail_d = in_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/compressor_stream_arbiter.sv
// Round-robin packet arbiter feeding one compressor stream; grant held for a whole packet.
// Accepted beat reaches m side next cycle; s_tready follows only registered buffer occupancy.
module compressor_stream_arbiter
  import compressor_stream_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
  localparam int ID_W      = id_width(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arb_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  output logic [NUM_PORTS-1:0]           s_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [KEEP_WIDTH-1:0]          m_tkeep,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  output logic [ID_W-1:0]                m_tid,
  input  logic                           m_tready,
  output logic                           busy,
  output logic [31:0]                    pkt_count
);

  localparam int IDX_W = ID_W + 1;
  localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_W;

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [31:0]           pkt_count_q, pkt_count_d;
  logic [ID_W-1:0]       pick;
  logic [IDX_W-1:0]      idx_w;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last, sel_vld;
  logic                  buf_rdy, beat_acc;
  logic [PAY_W-1:0]      out_pay;

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    sel_vld  = 1'b0;
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_data    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep    = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_last    = s_tlast[i];
        sel_vld     = s_tvalid[i];
        s_tready[i] = (state_q == STREAM) && buf_rdy;
      end
    end
  end

  assign beat_acc = (state_q == STREAM) && sel_vld && buf_rdy;

  // Walk downward so the lowest offset from rr_ptr is the one left in pick.
  always_comb begin
    pick  = '0;
    idx_w = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx_w = {1'b0, rr_ptr_q} + IDX_W'(i);
      if (idx_w >= IDX_W'(NUM_PORTS)) idx_w = idx_w - IDX_W'(NUM_PORTS);
      if (s_tvalid[idx_w[ID_W-1:0]]) pick = idx_w[ID_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (arb_en && (|s_tvalid)) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat_acc && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (m_tvalid && m_tready && m_tlast) pkt_count_d = pkt_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .core_clk (clk),
    .arst_n   (reset),
    .in_vld   (beat_acc),
    .in_rdy   (buf_rdy),
    .in_dat   ({sel_data, sel_keep, sel_last, grant_q}),
    .out_vld  (m_tvalid),
    .out_rdy  (m_tready),
    .out_dat  (out_pay)
  );

  assign {m_tdata, m_tkeep, m_tlast, m_tid} = out_pay;
  assign busy      = (state_q == STREAM) || m_tvalid;
  assign pkt_count = pkt_count_q;

endmodule
